// File: rtl/synth_pkg.sv
// Types and constants shared by the wavetable, voice RAM and mixer blocks.
package synth_pkg;

   localparam int unsigned SAMPLE_W    = 16;
   localparam int unsigned VOICE_IDX_W = 8;

   localparam logic [1:0] PS_READ    = 2'd0;
   localparam logic [1:0] PS_COMPUTE = 2'd1;
   localparam logic [1:0] PS_UPDATE  = 2'd2;

   typedef enum logic [0:0] {
      WAIT_SYNC = 1'b0,
      ACCUM     = 1'b1
   } mix_state_e;

endpackage

// File: rtl/mix_saturate.sv
// Scales a signed frame sum by an arithmetic right shift and clamps it to 16 bits.
module mix_saturate
   import synth_pkg::*;
#(
   parameter int unsigned ACC_W = 24,
   parameter int unsigned SHIFT = 3
) (
   input  logic signed [ACC_W-1:0]    i_sum,
   output logic signed [SAMPLE_W-1:0] o_sat,
   output logic                       o_clip
);

   logic signed [ACC_W-1:0]      scaled;
   logic        [ACC_W-SAMPLE_W:0] hi_bits;

   assign scaled  = i_sum >>> SHIFT;
   assign hi_bits = scaled[ACC_W-1:SAMPLE_W-1];

   // In range only when every bit above the 16-bit sign bit matches it.
   always_comb begin
      o_clip = 1'b0;
      o_sat  = scaled[SAMPLE_W-1:0];
      if (!((&hi_bits) || (~|hi_bits))) begin
         o_clip = 1'b1;
         o_sat  = scaled[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
      end
   end

endmodule

// File: rtl/voice_mixer.sv
// Accumulates one gated sample per voice slot and hands each mixed frame to the
// DAC side over a valid/ready interface.
module voice_mixer
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 128,
   parameter int unsigned ACC_W      = 24,
   parameter int unsigned SHIFT      = 3
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [SAMPLE_W-1:0]    i_sample,
   input  logic [VOICE_IDX_W-1:0] i_voice_index,
   input  logic [1:0]             i_pipeline_state,
   input  logic                   i_voice_active,
   input  logic                   i_mix_ready,
   output logic [SAMPLE_W-1:0]    o_mix,
   output logic                   o_mix_valid,
   output logic                   o_clip,
   output logic                   o_frame_done,
   output logic                   o_overrun,
   output logic                   o_seq_err
);

   localparam logic [VOICE_IDX_W-1:0] LAST_IDX = VOICE_IDX_W'(NUM_VOICES - 1);

   mix_state_e                state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [VOICE_IDX_W-1:0]    exp_q, exp_d;
   logic [SAMPLE_W-1:0]       mix_q, mix_d;
   logic                      valid_q, valid_d;
   logic                      clip_q, clip_d;
   logic                      done_q, done_d;
   logic                      overrun_q, overrun_d;
   logic                      seq_err_q, seq_err_d;

   logic                      capture_c;
   logic                      start_c;
   logic                      frame_end_c;
   logic signed [ACC_W-1:0]   contrib_c;
   logic signed [ACC_W-1:0]   sum_c;
   logic signed [SAMPLE_W-1:0] sat_mix_c;
   logic                      sat_clip_c;

   assign capture_c = (i_pipeline_state == PS_UPDATE);
   assign contrib_c = i_voice_active
                    ? {{(ACC_W-SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample}
                    : '0;

   mix_saturate #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) u_sat (
      .i_sum  (sum_c),
      .o_sat  (sat_mix_c),
      .o_clip (sat_clip_c)
   );

   // Frame sequencing: index tracking, accumulation and frame-end detection.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      exp_d       = exp_q;
      seq_err_d   = seq_err_q;
      sum_c       = contrib_c;
      start_c     = 1'b0;
      frame_end_c = 1'b0;
      if (capture_c) begin
         case (state_q)
            WAIT_SYNC: begin
               if (i_voice_index == '0) start_c = 1'b1;
            end
            ACCUM: begin
               if (i_voice_index == exp_q) begin
                  sum_c = acc_q + contrib_c;
                  acc_d = sum_c;
                  exp_d = exp_q + VOICE_IDX_W'(1);
                  if (i_voice_index == LAST_IDX) frame_end_c = 1'b1;
               end else begin
                  seq_err_d = 1'b1;
                  acc_d     = '0;
                  exp_d     = '0;
                  state_d   = WAIT_SYNC;
                  if (i_voice_index == '0) start_c = 1'b1;
               end
            end
            default: ;
         endcase
         if (start_c) begin
            acc_d   = contrib_c;
            exp_d   = VOICE_IDX_W'(1);
            state_d = ACCUM;
            if (i_voice_index == LAST_IDX) frame_end_c = 1'b1;
         end
         if (frame_end_c) begin
            acc_d = '0;
            exp_d = '0;
         end
      end
   end

   // Output register and handshake; a frame end always wins over a transfer.
   always_comb begin
      mix_d     = mix_q;
      clip_d    = clip_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      done_d    = frame_end_c;
      if (valid_q && i_mix_ready) valid_d = 1'b0;
      if (frame_end_c) begin
         mix_d   = sat_mix_c;
         clip_d  = sat_clip_c;
         valid_d = 1'b1;
         if (valid_q && !i_mix_ready) overrun_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= WAIT_SYNC;
         acc_q     <= '0;
         exp_q     <= '0;
         mix_q     <= '0;
         valid_q   <= 1'b0;
         clip_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         exp_q     <= exp_d;
         mix_q     <= mix_d;
         valid_q   <= valid_d;
         clip_q    <= clip_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign o_mix        = mix_q;
   assign o_mix_valid  = valid_q;
   assign o_clip       = clip_q;
   assign o_frame_done = done_q;
   assign o_overrun    = overrun_q;
   assign o_seq_err    = seq_err_q;

endmodule
